// File: rtl/seq_mul_bip.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per
// operation, one partial product per clock, valid/ready handshakes on both sides.
module seq_mul_bip #(
   parameter int WIDTH     = 16,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic                 out_valid_q, out_valid_d;

   logic                 signed_op;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [2*WIDTH-1:0]   sum;

   // Two's-complement negation of -2^(WIDTH-1) yields 2^(WIDTH-1), which is the
   // correct magnitude when the result is read as unsigned.
   always_comb begin
      signed_op = SIGNED_EN && is_signed;
      a_mag     = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      b_mag     = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      sum       = acc_q + (mcand_q[0] ? mplier_q : '0);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      neg_d       = neg_q;
      prod_d      = prod_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d  = a_mag;
               mplier_d = {{WIDTH{1'b0}}, b_mag};
               neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            // Multiplier shifts left one place per step, so it is always aligned
            // with the multiplicand bit currently at mcand_q[0].
            acc_d    = sum;
            mcand_d  = mcand_q >> 1;
            mplier_d = mplier_q << 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               prod_d      = neg_q ? -sum : sum;
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         neg_q       <= 1'b0;
         prod_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         neg_q       <= neg_d;
         prod_q      <= prod_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign prod      = prod_q;
endmodule
